// File: rtl/ct_vfdsu_scalar_ctrl_pkg.sv
// Shared definitions for the scalar FP divide/sqrt control path:
// state encoding, iteration counts and the counter load selection.
package ct_vfdsu_scalar_ctrl_pkg;

  localparam int unsigned ITER_DBL  = 28;
  localparam int unsigned ITER_SGL  = 13;
  localparam int unsigned ITER_HALF = 7;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EX1  = 3'd1,
    ST_ITER = 3'd2,
    ST_RND  = 3'd3,
    ST_WB   = 3'd4
  } vfdsu_state_e;

  typedef struct packed {
    logic special;
    logic dbl;
    logic sgl;
  } ex1_op_t;

  // Remaining-iteration count loaded on entry to ITER; specials get a single pass.
  function automatic logic [CNT_W-1:0] iter_load_val(input ex1_op_t op);
    logic [CNT_W-1:0] val;
    if (op.special)  val = '0;
    else if (op.dbl) val = CNT_W'(ITER_DBL - 1);
    else if (op.sgl) val = CNT_W'(ITER_SGL - 1);
    else             val = CNT_W'(ITER_HALF - 1);
    return val;
  endfunction

endpackage

// File: rtl/ct_vfdsu_scalar_ctrl_iter_cnt.sv
// Loadable down-counter tracking remaining SRT iterations, with zero flag.
module ct_vfdsu_iter_cnt
  import ct_vfdsu_scalar_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             ld_special_i,
  input  logic             ld_double_i,
  input  logic             ld_single_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  ex1_op_t          ld_op;

  assign ld_op = '{special: ld_special_i, dbl: ld_double_i, sgl: ld_single_i};

  // Clear beats load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = iter_load_val(ld_op);
    else if (dec_i)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ct_vfdsu_scalar_ctrl.sv
// Scalar FP div/sqrt pipeline control: EX1 -> ITER -> RND -> WB sequencing,
// pipedown/iteration strobes and a held writeback request.
module ct_vfdsu_scalar_ctrl
  import ct_vfdsu_scalar_ctrl_pkg::*;
(
  input  logic             vfdsu_sew_clk,
  input  logic             cpurst_b,
  input  logic             rf_issue_vld,
  input  logic             ex1_div,
  input  logic             ex1_sqrt,
  input  logic             ex1_double,
  input  logic             ex1_single,
  input  logic             ex1_special,
  input  logic             rtu_flush,
  input  logic             wb_grant,
  output logic             vfdsu_busy,
  output logic             ex1_pipedown,
  output logic             ex2_pipedown,
  output logic             ex3_pipedown,
  output logic             srt_iter_en,
  output logic             srt_first_iter,
  output logic             rnd_en,
  output logic             wb_req,
  output logic [CNT_W-1:0] iter_cnt
);

  vfdsu_state_e     state_q, state_d;
  logic             ex1_special_q, ex1_special_d;
  logic             first_iter_q, first_iter_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             unused_op_type;

  // Divide and sqrt share identical sequencing.
  assign unused_op_type = ex1_div ^ ex1_sqrt;

  always_ff @(posedge vfdsu_sew_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= ST_IDLE;
      ex1_special_q <= 1'b0;
      first_iter_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex1_special_q <= ex1_special_d;
      first_iter_q  <= first_iter_d;
    end
  end

  // Next state and Moore output decode; flush overrides everything at the end.
  always_comb begin
    state_d        = state_q;
    ex1_special_d  = ex1_special_q;
    first_iter_d   = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    ex1_pipedown   = 1'b0;
    ex2_pipedown   = 1'b0;
    ex3_pipedown   = 1'b0;
    srt_iter_en    = 1'b0;
    srt_first_iter = 1'b0;
    rnd_en         = 1'b0;
    wb_req         = 1'b0;
    vfdsu_busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (rf_issue_vld) state_d = ST_EX1;
      end
      ST_EX1: begin
        state_d       = ST_ITER;
        ex1_special_d = ex1_special;
        first_iter_d  = 1'b1;
        cnt_load      = 1'b1;
        ex1_pipedown  = 1'b1;
      end
      ST_ITER: begin
        if (cnt_zero) state_d = ST_RND;
        else          cnt_dec = 1'b1;
        srt_iter_en    = ~ex1_special_q;
        srt_first_iter = first_iter_q;
        ex2_pipedown   = cnt_zero;
      end
      ST_RND: begin
        state_d      = ST_WB;
        rnd_en       = 1'b1;
        ex3_pipedown = 1'b1;
      end
      ST_WB: begin
        wb_req = 1'b1;
        if (wb_grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rtu_flush) begin
      state_d        = ST_IDLE;
      ex1_special_d  = 1'b0;
      first_iter_d   = 1'b0;
      cnt_load       = 1'b0;
      cnt_dec        = 1'b0;
      ex1_pipedown   = 1'b0;
      ex2_pipedown   = 1'b0;
      ex3_pipedown   = 1'b0;
      srt_iter_en    = 1'b0;
      srt_first_iter = 1'b0;
      rnd_en         = 1'b0;
      wb_req         = 1'b0;
    end
  end

  ct_vfdsu_iter_cnt u_iter_cnt (
    .clk_i        (vfdsu_sew_clk),
    .rst_n_i      (cpurst_b),
    .clr_i        (rtu_flush),
    .load_i       (cnt_load),
    .ld_special_i (ex1_special),
    .ld_double_i  (ex1_double),
    .ld_single_i  (ex1_single),
    .dec_i        (cnt_dec),
    .cnt_o        (cnt),
    .zero_o       (cnt_zero)
  );

  assign iter_cnt = cnt;

endmodule

// File: tb/tb_ct_vfdsu_scalar_ctrl.sv
// Randomized scoreboard bench for the scalar div/sqrt control FSM.
module tb_ct_vfdsu_scalar_ctrl;
  import ct_vfdsu_scalar_ctrl_pkg::*;

  logic vfdsu_sew_clk = 1'b0;
  logic cpurst_b = 1'b0, rf_issue_vld = 1'b0, ex1_div = 1'b0, ex1_sqrt = 1'b0;
  logic ex1_double = 1'b0, ex1_single = 1'b0, ex1_special = 1'b0;
  logic rtu_flush = 1'b0, wb_grant = 1'b0;
  logic vfdsu_busy, ex1_pipedown, ex2_pipedown, ex3_pipedown;
  logic srt_iter_en, srt_first_iter, rnd_en, wb_req;
  logic [CNT_W-1:0] iter_cnt;

  ct_vfdsu_scalar_ctrl dut (
    .vfdsu_sew_clk (vfdsu_sew_clk),
    .cpurst_b      (cpurst_b),
    .rf_issue_vld  (rf_issue_vld),
    .ex1_div       (ex1_div),
    .ex1_sqrt      (ex1_sqrt),
    .ex1_double    (ex1_double),
    .ex1_single    (ex1_single),
    .ex1_special   (ex1_special),
    .rtu_flush     (rtu_flush),
    .wb_grant      (wb_grant),
    .vfdsu_busy    (vfdsu_busy),
    .ex1_pipedown  (ex1_pipedown),
    .ex2_pipedown  (ex2_pipedown),
    .ex3_pipedown  (ex3_pipedown),
    .srt_iter_en   (srt_iter_en),
    .srt_first_iter(srt_first_iter),
    .rnd_en        (rnd_en),
    .wb_req        (wb_req),
    .iter_cnt      (iter_cnt)
  );

  always #5 vfdsu_sew_clk = ~vfdsu_sew_clk;

  typedef struct {
    int issue_cyc;
    int n;
    bit special;
    int wr_cyc;   // cycle of the accepted writeback, -1 if none is expected
  } exp_op_t;

  exp_op_t sb_q[$];
  int cyc = 0;
  int vectors = 0, errors = 0;
  int exp_writes = 0, act_writes = 0;

  always @(posedge vfdsu_sew_clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge vfdsu_sew_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Number of ITER cycles an operation spends.
  function automatic int n_of(input bit sp, input bit dbl, input bit sgl);
    if (sp) return 1;
    if (dbl) return 28;
    if (sgl) return 13;
    return 7;
  endfunction

  // Expected strobes at offset k from issue: {busy,ex1,ex2,ex3,iter_en,first,rnd,wb}.
  function automatic logic [7:0] exp_vec(input int k, input int n, input bit sp, input bit fl);
    logic busy, e1, e2, it, fi, rn, wb;
    busy = (k >= 1);
    e1   = (k == 1);
    it   = (k >= 2) && (k <= 1 + n);
    fi   = (k == 2);
    e2   = (k == 1 + n);
    rn   = (k == 2 + n);
    wb   = (k >= 3 + n);
    if (fl) begin
      e1 = 1'b0; e2 = 1'b0; it = 1'b0; fi = 1'b0; rn = 1'b0; wb = 1'b0;
    end
    return {busy, e1, e2, rn, it & ~sp, fi, rn, wb};
  endfunction

  logic [7:0]  m_exp_v, m_act_v;
  logic [31:0] m_exp_c;
  logic        m_exp_wr, m_act_wr;
  int          m_k;

  // Monitor: compare every cycle against the operation at the head of the scoreboard.
  always @(negedge vfdsu_sew_clk) begin
    m_exp_v  = '0;
    m_exp_c  = '0;
    m_exp_wr = 1'b0;
    m_k      = 0;
    if (cpurst_b && sb_q.size() > 0) begin
      m_k      = cyc - sb_q[0].issue_cyc;
      m_exp_v  = exp_vec(m_k, sb_q[0].n, sb_q[0].special, rtu_flush);
      m_exp_c  = ((m_k >= 2) && (m_k <= 1 + sb_q[0].n)) ? 32'(sb_q[0].n + 1 - m_k) : 32'd0;
      m_exp_wr = (sb_q[0].wr_cyc == cyc);
    end
    m_act_v  = {vfdsu_busy, ex1_pipedown, ex2_pipedown, ex3_pipedown,
                srt_iter_en, srt_first_iter, rnd_en, wb_req};
    m_act_wr = wb_req & wb_grant & ~rtu_flush;
    if (m_act_wr) act_writes++;
    check("strobes", 32'(m_act_v), 32'(m_exp_v));
    check("iter_cnt", 32'(iter_cnt), m_exp_c);
    check("write", 32'(m_act_wr), 32'(m_exp_wr));
    if (!cpurst_b) sb_q.delete();
    else if (sb_q.size() > 0 && (m_exp_wr || rtu_flush)) void'(sb_q.pop_front());
  end

  // One operation from issue to completion, flush (flush_at) or reset (rst_at).
  task automatic run_op(input bit dbl, input bit sgl, input bit spec, input int gd,
                        input bit cont, input int flush_at, input int rst_at);
    int n, wb0, last;
    exp_op_t e;
    n    = n_of(spec, dbl, sgl);
    wb0  = 3 + n;
    last = wb0 + gd;
    ex1_double   = dbl;
    ex1_single   = sgl;
    ex1_special  = spec;
    ex1_div      = 1'($urandom);
    ex1_sqrt     = 1'($urandom);
    rf_issue_vld = 1'b1;
    rtu_flush    = 1'b0;
    wb_grant     = cont ? 1'b1 : 1'($urandom);
    e.issue_cyc  = cyc;
    e.n          = n;
    e.special    = spec;
    e.wr_cyc     = ((flush_at >= 1 && flush_at <= last) || (rst_at >= 1 && rst_at <= last))
                   ? -1 : cyc + last;
    sb_q.push_back(e);
    if (e.wr_cyc >= 0) exp_writes++;
    for (int k = 1; k <= last; k++) begin
      step();
      rf_issue_vld = 1'($urandom);
      if (cont)         wb_grant = 1'b1;
      else if (k < wb0) wb_grant = 1'($urandom);
      else              wb_grant = (k == last);
      if (k == rst_at) begin
        rf_issue_vld = 1'b0;
        cpurst_b = 1'b0;
        step();
        step();
        cpurst_b = 1'b1;
        wb_grant = 1'b0;
        return;
      end
      if (k == flush_at) begin
        rtu_flush = 1'b1;
        step();
        rtu_flush    = 1'b0;
        rf_issue_vld = 1'b0;
        wb_grant     = 1'b0;
        return;
      end
    end
    step();
    rf_issue_vld = 1'b0;
    wb_grant     = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    cpurst_b = 1'b1;
    step();
    step();
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b1, -1, -1);   // double, grant held high
    run_op(1'b0, 1'b1, 1'b0, 5, 1'b0, -1, -1);   // single, grant late by 5
    run_op(1'b0, 1'b0, 1'b1, 0, 1'b1, -1, -1);   // back-to-back half special
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b1, 10, -1);   // flush mid-iteration
    run_op(1'b0, 1'b1, 1'b0, 2, 1'b0, 18, -1);   // flush with grant in WB
    rf_issue_vld = 1'b1;                          // issue dropped by flush in IDLE
    rtu_flush    = 1'b1;
    step();
    rf_issue_vld = 1'b0;
    rtu_flush    = 1'b0;
    step();
    step();
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b1, -1, 15);   // reset mid-operation
    run_op(1'b1, 1'b0, 1'b0, 0, 1'b1, -1, -1);
    run_op(1'b1, 1'b1, 1'b0, 1, 1'b0, -1, -1);   // both precision bits: double
    for (int i = 0; i < 40; i++) begin
      bit d, s, sp, ct;
      int gd, n, last, fa;
      d    = 1'($urandom);
      s    = 1'($urandom);
      sp   = ($urandom_range(0, 3) == 0);
      ct   = 1'($urandom);
      gd   = ct ? 0 : int'($urandom_range(0, 4));
      n    = n_of(sp, d, s);
      last = 3 + n + gd;
      fa   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, last)) : -1;
      run_op(d, s, sp, gd, ct, fa, -1);
      repeat ($urandom_range(0, 2)) begin
        wb_grant  = 1'($urandom);
        rtu_flush = ($urandom_range(0, 4) == 0);
        step();
      end
      rtu_flush = 1'b0;
      wb_grant  = 1'b0;
    end
    repeat (3) step();
    check("write_count", 32'(act_writes), 32'(exp_writes));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
